// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer with one full-adder slice
// Optional subtract support is enabled by defining SERIAL_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             load;
  logic             last;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] b_load;
  logic             c_seed;

`ifdef SERIAL_SUB_EN
  assign b_load = sub ? ~B : B;
  assign c_seed = sub;
`else
  assign b_load = B;
  assign c_seed = 1'b0;
`endif

  assign last = (cnt == CW'(WIDTH - 1));
  assign fa_s = reg_a[0] ^ reg_b[0] ^ c;
  assign fa_c = (reg_a[0] & reg_b[0]) | (c & (reg_a[0] ^ reg_b[0]));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (strt) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (strt) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovfl  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        reg_a <= A;
        reg_b <= b_load;
        c     <= c_seed;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        sum   <= {fa_s, sum[WIDTH-1:1]};
        reg_a <= {1'b0, reg_a[WIDTH-1:1]};
        reg_b <= {1'b0, reg_b[WIDTH-1:1]};
        c     <= fa_c;
        cnt   <= cnt + 1'b1;
        // The carry entering the MSB slice is c itself on the last bit.
        if (last) begin
          cout <= fa_c;
          ovfl <= c ^ fa_c;
        end
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
